serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial subtractor: computes Diff = A - B - Bin, one bit per clock, LSB first.
//   Produces borrow-out and signed overflow.
//   The sequential, inverse-operation counterpart of the team's 4-bit ripple-carry adder.
//   Used where area matters more than latency; controlled by a start/busy/done handshake.
//
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>= 2)
//
// PORTS
//   clk    input   1      rising-edge clock (single clock domain)
//   rst    input   1      synchronous, active-high reset
//   start  input   1      request; sampled only when busy=0
//   A      input   WIDTH  minuend, captured on accepted start
//   B      input   WIDTH  subtrahend, captured on accepted start
//   Bin    input   1      borrow-in, captured on accepted start
//   busy   output  1      1 while a subtraction is in progress
//   done   output  1      one-cycle pulse: Diff/Bout/Ovf just updated
//   Diff   output  WIDTH  result A - B - Bin (mod 2^WIDTH)
//   Bout   output  1      borrow-out: 1 iff A < B + Bin (unsigned)
//   Ovf    output  1      signed overflow of two's-complement A - B - Bin
//
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, Diff=0, Bout=0, Ovf=0.
//     Internal shift regs and bit counter cleared. Overrides start.
//   - FSM states:
//     - IDLE: start=1 at edge k -> latch A, B, Bin; counter=0; go RUN; busy=1 after edge k.
//     - RUN: each edge processes bit i = counter with live borrow br (init Bin):
//       d_i = a_i ^ b_i ^ br;  br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
//       After bit WIDTH-1 (edge k+WIDTH), return to IDLE.
//   - Latency: done=1 in the cycle after edge k+WIDTH, i.e. WIDTH cycles after acceptance.
//     At that same edge: Diff, Bout=final br, Ovf=(A[W-1]^B[W-1]) & (A[W-1]^Diff[W-1])
//     using the latched operands; busy=0.
//   - Diff/Bout/Ovf change only at completion. They hold the previous result during RUN
//     and until the next completion.
//   - done is high exactly one cycle, then 0.
//   - start while busy=1: ignored, no effect on operands or timing.
//   - start in the done cycle (busy=0): accepted. done drops next cycle, busy rises.
//     Back-to-back throughput is one result per WIDTH+1 cycles.
//   - A/B/Bin changes after acceptance: no effect on the in-flight result.
//   - Reset mid-RUN: operation aborted, no done pulse, outputs return to reset values.
//   - Counter width is $clog2(WIDTH); wraps only via return to IDLE.
//
// TESTING (WIDTH=4)
//   1. A=5, B=3, Bin=0, start 1 cycle
//      -> busy 4 cycles; done with Diff=4'h2, Bout=0, Ovf=0.
//   2. A=3, B=5, Bin=0 -> Diff=4'hE, Bout=1, Ovf=0.
//      A=0, B=0, Bin=1 -> Diff=4'hF, Bout=1, Ovf=0.
//   3. A=8 (-8), B=1, Bin=0 -> Diff=4'h7, Bout=0, Ovf=1.
//      A=7, B=15 (-1), Bin=0 -> Diff=4'h8, Bout=1, Ovf=1.
//   4. Start A=15, B=15, Bin=1; at 2nd busy cycle pulse start with A=1, B=0
//      -> single done, Diff=4'hF, Bout=1; no second done.
//   5. Start A=9, B=2; rst at 2nd busy cycle -> busy=0, done never asserts, Diff=0, Bout=0.
//      Next start A=9, B=2 -> Diff=4'h7.
//   6. Start in the done cycle of A=6, B=6 (Diff=0) with A=2, B=1
//      -> second done exactly 5 cycles after the first, Diff=4'h1.

Source files
------------

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Start/busy/done handshake and operand/result bundle for the
//                bit-serial subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout, Ovf
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout, Ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial Diff = A - B - Bin, LSB first, one bit per clock,
//                with borrow-out and signed overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int               c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [0:0]       c_idle = 1'b0;
    localparam logic [0:0]       c_run  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-2:0]   r_dsh;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_br;
    logic [WIDTH-1:0]   w_dsh_full;

    assign w_accept   = (r_state == c_idle) && bus.start;
    assign w_last     = (r_state == c_run) && (r_cnt == c_last);
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br       = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    // Result bits enter at the MSB so the word is aligned after the last bit.
    assign w_dsh_full = {w_d, r_dsh};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (bus.start) w_next_state = c_run;
            c_run:   if (r_cnt == c_last) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_dsh   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= bus.A;
                r_b     <= bus.B;
                r_br    <= bus.Bin;
                r_cnt   <= '0;
                r_a_msb <= bus.A[WIDTH-1];
                r_b_msb <= bus.B[WIDTH-1];
            end else if (r_state == c_run) begin
                r_a   <= {1'b0, r_a[WIDTH-1:1]};
                r_b   <= {1'b0, r_b[WIDTH-1:1]};
                r_br  <= w_br;
                r_cnt <= r_cnt + 1'b1;
                r_dsh <= w_dsh_full[WIDTH-1:1];
                if (w_last) begin
                    r_diff <= w_dsh_full;
                    r_bout <= w_br;
                    // w_d is the result MSB on the final bit.
                    r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (r_state == c_run);
    assign bus.done = r_done;
    assign bus.Diff = r_diff;
    assign bus.Bout = r_bout;
    assign bus.Ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (WIDTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(W)) sif();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: plain integer subtraction, unsigned and signed views.
    function automatic void ref_sub(input int a, input int b, input int bin,
                                    output logic [W-1:0] d, output logic bo,
                                    output logic ov);
        int sa, sb, res;
        d  = W'((a - b - bin) & ((1 << W) - 1));
        bo = (a < b + bin);
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        res = sa - sb - bin;
        ov = (res < -(1 << (W - 1))) || (res >= (1 << (W - 1)));
    endfunction

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic         m_ovf  = 1'b0;
    int           m_left = 0;
    logic [W-1:0] p_diff = '0;
    logic         p_bout = 1'b0;
    logic         p_ovf  = 1'b0;

    always @(posedge clk) begin : model
        logic [W-1:0] td;
        logic         tbo;
        logic         tov;
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_diff <= p_diff;
                    m_bout <= p_bout;
                    m_ovf  <= p_ovf;
                end
            end else if (sif.start) begin
                ref_sub(int'(sif.A), int'(sif.B), int'(sif.Bin), td, tbo, tov);
                p_diff <= td;
                p_bout <= tbo;
                p_ovf  <= tov;
                m_busy <= 1'b1;
                m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (sif.busy !== m_busy || sif.done !== m_done || sif.Diff !== m_diff ||
            sif.Bout !== m_bout || sif.Ovf !== m_ovf) begin
            errors++;
            $display("FAIL cycle t=%0t got busy=%b done=%b Diff=%h Bout=%b Ovf=%b expected busy=%b done=%b Diff=%h Bout=%b Ovf=%b",
                     $time, sif.busy, sif.done, sif.Diff, sif.Bout, sif.Ovf,
                     m_busy, m_done, m_diff, m_bout, m_ovf);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input int a, input int b, input int bin);
        @(negedge clk);
        sif.start = 1'b1;
        sif.A     = W'(a);
        sif.B     = W'(b);
        sif.Bin   = bin[0];
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (sif.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sif.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done-timeout: got done=%b expected 1 within 20 cycles", sif.done);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sif.done === 1'b1) cnt++;
        end
    endtask

    int n;
    int cnt;
    int va [4] = '{12, 4, 15, 0};
    int vb [4] = '{5, 9, 0, 15};
    int vc [4] = '{1, 1, 0, 1};
    int ed [4] = '{6, 10, 15, 0};
    int eo [4] = '{1, 1, 0, 0};

    initial begin
        sif.start = 1'b0;
        sif.A     = '0;
        sif.B     = '0;
        sif.Bin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", 32'(sif.busy), 0);
        chk("reset done", 32'(sif.done), 0);
        chk("reset Diff", 32'(sif.Diff), 0);

        // 5 - 3 - 0
        do_start(5, 3, 0);
        wait_done(n);
        chk("t1 latency", n, 4);
        chk("t1 Diff", 32'(sif.Diff), 2);
        chk("t1 Bout", 32'(sif.Bout), 0);
        chk("t1 Ovf", 32'(sif.Ovf), 0);
        chk("t1 model Diff", 32'(m_diff), 2);

        do_start(3, 5, 0);
        wait_done(n);
        chk("t2a Diff", 32'(sif.Diff), 32'hE);
        chk("t2a Bout", 32'(sif.Bout), 1);
        do_start(0, 0, 1);
        wait_done(n);
        chk("t2b Diff", 32'(sif.Diff), 32'hF);
        chk("t2b Bout", 32'(sif.Bout), 1);
        chk("t2b Ovf", 32'(sif.Ovf), 0);

        do_start(8, 1, 0);
        wait_done(n);
        chk("t3a Diff", 32'(sif.Diff), 7);
        chk("t3a Bout", 32'(sif.Bout), 0);
        chk("t3a Ovf", 32'(sif.Ovf), 1);
        do_start(7, 15, 0);
        wait_done(n);
        chk("t3b Diff", 32'(sif.Diff), 8);
        chk("t3b Bout", 32'(sif.Bout), 1);
        chk("t3b Ovf", 32'(sif.Ovf), 1);

        // start pulsed while busy must be ignored
        do_start(15, 15, 1);
        @(negedge clk);
        sif.start = 1'b1;
        sif.A     = 4'd1;
        sif.B     = 4'd0;
        sif.Bin   = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        wait_done(n);
        chk("t4 Diff", 32'(sif.Diff), 32'hF);
        chk("t4 Bout", 32'(sif.Bout), 1);
        count_dones(10, cnt);
        chk("t4 extra dones", cnt, 0);

        // reset mid-run aborts the operation
        do_start(9, 2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_dones(8, cnt);
        chk("t5 dones after abort", cnt, 0);
        chk("t5 busy", 32'(sif.busy), 0);
        chk("t5 Diff", 32'(sif.Diff), 0);
        chk("t5 Bout", 32'(sif.Bout), 0);
        do_start(9, 2, 0);
        wait_done(n);
        chk("t5 retry Diff", 32'(sif.Diff), 7);

        // start accepted in the done cycle
        do_start(6, 6, 0);
        wait_done(n);
        chk("t6 first Diff", 32'(sif.Diff), 0);
        sif.start = 1'b1;
        sif.A     = 4'd2;
        sif.B     = 4'd1;
        sif.Bin   = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        chk("t6 done drops", 32'(sif.done), 0);
        chk("t6 busy rises", 32'(sif.busy), 1);
        wait_done(n);
        chk("t6 done spacing", n + 1, 5);
        chk("t6 Diff", 32'(sif.Diff), 1);

        for (int i = 0; i < 4; i++) begin
            do_start(va[i], vb[i], vc[i]);
            wait_done(n);
            chk("vec Diff", 32'(sif.Diff), 32'(ed[i]));
            chk("vec Ovf", 32'(sif.Ovf), 32'(eo[i]));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
